// File: rtl/spi_pkg.sv
// Shared types and constants for the serial frame transmitter.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } spi_state_e;

  // Line levels of the idle-high frame format.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity mode codes.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/spi_tx_if.sv
// Upstream word handshake into the transmitter.
interface spi_tx_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/spi_tx_hold.sv
// One-deep valid/ready holding register queuing the next word during a frame.
module spi_tx_hold
  import spi_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         spi_clk_rx,
  input  logic         RST_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_take,
  output logic [W-1:0] out_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  assign in_ready  = !r_full;
  assign out_valid = r_full;
  assign out_data  = r_data;

  // Write only when empty; a take empties it. Both at once cannot occur.
  always_ff @(posedge spi_clk_rx) begin
    if (!RST_n) begin
      r_full <= 1'b0;
      r_data <= '1;
    end else if (in_valid && !r_full) begin
      r_full <= 1'b1;
      r_data <= in_data;
    end else if (out_take) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_tx.sv
// Start/data/parity/stop frame serialiser, LSB first, idle-high, one bit per clock.
module spi_tx
  import spi_pkg::*;
#(
  parameter int unsigned txd_bit_num = 8,
  parameter int unsigned PARITY      = 0
) (
  input  logic    spi_clk_rx,
  input  logic    RST_n,
  spi_tx_if.slave bus,
  output logic    spi_tx_data,
  output logic    spi_busy,
  output logic    spi_over
);

  localparam int unsigned all_bit_num = txd_bit_num + 2 + ((PARITY != PAR_NONE) ? 1 : 0);
  localparam int unsigned CNT_W       = $clog2(txd_bit_num + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(txd_bit_num - 1);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_START = 3'(ST_START);
  localparam logic [2:0] S_DATA  = 3'(ST_DATA);
  localparam logic [2:0] S_PAR   = 3'(ST_PAR);
  localparam logic [2:0] S_STOP  = 3'(ST_STOP);

  if (all_bit_num < 3 || PARITY > PAR_ODD) begin : g_cfg_err
    $error("spi_tx: unsupported txd_bit_num/PARITY configuration");
  end

  logic [2:0]             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [txd_bit_num-1:0] r_shift, w_shift_nxt;
  logic                   r_par, w_par_nxt;
  logic                   r_line, w_line_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_over, w_over_nxt;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_hold_wr;
  logic                   w_hold_take;
  logic                   w_hold_valid;
  logic [txd_bit_num-1:0] w_in_data;
  logic [txd_bit_num-1:0] w_hold_data;

  assign w_in_data    = bus.tx_data;
  assign bus.tx_ready = w_in_ready;
  assign w_accept     = bus.tx_valid && w_in_ready && RST_n;

  assign spi_tx_data = r_line;
  assign spi_busy    = r_busy;
  assign spi_over    = r_over;

  function automatic logic par_of(input logic [txd_bit_num-1:0] word);
    return (PARITY == PAR_EVEN) ? ^word : ~^word;
  endfunction

  spi_tx_hold #(.W(txd_bit_num)) u_hold (
    .spi_clk_rx (spi_clk_rx),
    .RST_n      (RST_n),
    .in_valid   (w_hold_wr),
    .in_ready   (w_in_ready),
    .in_data    (w_in_data),
    .out_valid  (w_hold_valid),
    .out_take   (w_hold_take),
    .out_data   (w_hold_data)
  );

  // Next state plus the line level for the next cycle, so the line stays registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_line_nxt  = LINE_IDLE;
    w_hold_wr   = 1'b0;
    w_hold_take = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = w_in_data;
          w_par_nxt   = par_of(w_in_data);
          w_state_nxt = S_START;
          w_line_nxt  = START_BIT;
        end
      end
      S_START: begin
        w_hold_wr   = w_accept;
        w_state_nxt = S_DATA;
        w_cnt_nxt   = '0;
        w_line_nxt  = r_shift[0];
        w_shift_nxt = txd_bit_num'({1'b1, r_shift} >> 1);
      end
      S_DATA: begin
        w_hold_wr = w_accept;
        // r_cnt indexes the bit currently on the line.
        if (r_cnt == CNT_LAST) begin
          if (PARITY != PAR_NONE) begin
            w_state_nxt = S_PAR;
            w_line_nxt  = r_par;
          end else begin
            w_state_nxt = S_STOP;
            w_line_nxt  = STOP_BIT;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_line_nxt  = r_shift[0];
          w_shift_nxt = txd_bit_num'({1'b1, r_shift} >> 1);
        end
      end
      S_PAR: begin
        w_hold_wr   = w_accept;
        w_state_nxt = S_STOP;
        w_line_nxt  = STOP_BIT;
      end
      S_STOP: begin
        // Held word takes priority; tx_ready is low then, so no accept can race it.
        if (w_hold_valid) begin
          w_hold_take = 1'b1;
          w_shift_nxt = w_hold_data;
          w_par_nxt   = par_of(w_hold_data);
          w_state_nxt = S_START;
          w_line_nxt  = START_BIT;
        end else if (w_accept) begin
          w_shift_nxt = w_in_data;
          w_par_nxt   = par_of(w_in_data);
          w_state_nxt = S_START;
          w_line_nxt  = START_BIT;
        end else begin
          w_state_nxt = S_IDLE;
          w_line_nxt  = LINE_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_over_nxt = (w_state_nxt == S_STOP);
  end

  always_ff @(posedge spi_clk_rx) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '1;
      r_par   <= 1'b0;
      r_line  <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_line  <= w_line_nxt;
      r_busy  <= w_busy_nxt;
      r_over  <= w_over_nxt;
    end
  end

endmodule

// File: doc/spi_tx.md
# spi_tx

Serial transmitter that serialises parallel words into start/data/stop frames, one bit per `spi_clk_rx` cycle, LSB first, idle-high line. It is the sending end of the link whose receive side shifts `txd_bit_num` data bits LSB-first inside a start/stop frame. A one-deep holding register lets the upstream producer queue the next word while the current frame shifts out, so back-to-back frames have no idle gap.

## Interface
- `txd_bit_num`, 8, data bits per frame (≥1)
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd; parity bit follows the MSB
- `all_bit_num`, `txd_bit_num+2+(PARITY!=0)`, total bits per frame (derived; never overridden)

Ports:
- `spi_clk_rx`  in  1  bit clock; all logic on the rising edge
- `RST_n`  in  1  reset, synchronous, active-low
- `tx_data`  in  `txd_bit_num`  word to send
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  holding register empty; a word is accepted on `tx_valid && tx_ready`
- `spi_tx_data`  out  1  serial line, registered
- `spi_busy`  out  1  a frame is in progress (START..STOP)
- `spi_over`  out  1  one-cycle pulse coincident with each stop bit

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: drive 1. On acceptance, load the word into the shift register and go to START.
  - START: drive 0 for one cycle, then DATA with `cnt=0`.
  - DATA: drive `shift[0]`, shift right, `cnt++`. After bit `txd_bit_num-1`, go to PAR if `PARITY!=0`, else STOP.
  - PAR: drive `^word` for even parity or `~^word` for odd. The parity value is captured at load.
  - STOP: drive 1 and pulse `spi_over`. Then:
    - if the holding register is full, move its word into the shift register, clear hold, and go to START (no idle cycle);
    - else if a word is accepted this cycle, load it directly and go to START;
    - else go to IDLE.
- Holding register:
  - A word accepted while not in IDLE is written to hold; `tx_ready = !hold_full`.
  - Accept and drain in the same cycle (STOP with hold full and `tx_valid` high) are impossible because `tx_ready` is 0. No word is lost or duplicated.
- `cnt` width is `$clog2(txd_bit_num+1)`. It never wraps mid-frame.
- `tx_data` changes while `tx_valid` is high and `tx_ready` is low are ignored; the word is sampled only at acceptance.
- Reset values: `spi_tx_data=1`, `spi_busy=0`, `spi_over=0`, `hold_full=0` (so `tx_ready=1`), state IDLE, `cnt=0`, shift register and hold all ones.
- Reset mid-frame: on the first edge with `RST_n=0`, the frame is abandoned, the line returns to 1, and the held word is discarded. `tx_valid` is ignored while `RST_n=0`.

## Timing
- The start bit appears on `spi_tx_data` in the cycle after the acceptance edge. It lasts exactly one cycle, as does every bit.
- Frame duration is `all_bit_num` cycles. `spi_busy` is high for exactly those cycles.
- `spi_over` is high only in the STOP cycle. With back-to-back frames it pulses every `all_bit_num` cycles.
- `tx_ready` falls the cycle after a word enters hold. It rises the cycle after the STOP that drains hold.
- Sustained throughput is one word per `all_bit_num` cycles.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, START, DATA, PAR, STOP);
  - constants for the line levels `LINE_IDLE=1`, `START_BIT=0`, `STOP_BIT=1`;
  - parity mode codes.
- Sub-module `spi_tx_hold`: one-deep valid/ready holding register (`in_valid/in_ready/in_data`, `out_valid/out_take/out_data`). The FSM and shifter stay in `spi_tx`.

## Test plan
- Single frame `0xA5`, `PARITY=0`:
  - line reads 1 (idle), then 0, then 1,0,1,0,0,1,0,1, then 1;
  - `spi_over` is high only on the 10th bit cycle;
  - `spi_busy` is high for 10 cycles; line is idle afterwards.
- Back-to-back `0x01` then `0xFF`, both offered immediately:
  - second word accepted during frame 1 and `tx_ready` goes 0;
  - frame 2 start bit directly follows frame 1 stop bit;
  - `spi_over` pulses 10 cycles apart.
- Backpressure: hold `tx_valid` with three words queued.
  - The third word is accepted only after the first STOP.
  - The line carries all three frames in order with no gaps or duplicates.
- Parity:
  - `PARITY=1`, word `0x07`: parity bit 1;
  - `PARITY=2`, word `0x07`: parity bit 0;
  - both cases give an 11-cycle frame.
- Reset mid-frame: assert `RST_n=0` during data bit 3 with hold full.
  - Next edge: line 1, `spi_busy=0`, `tx_ready=1`.
  - After release, a new word `0x3C` is sent cleanly and the old held word never appears.
- Boundary `txd_bit_num=1`: words 1 and 0 sent back-to-back.
  - Line reads 0,1,1 then 0,0,1.
  - `cnt` never exceeds 1.
